// File: rtl/error_frame_ctrl.sv
// rtl/error_frame_ctrl.sv - error flag / delimiter / intermission sequencer; err_cnt present only with ERR_FRAME_CNT_EN
module error_frame_ctrl #(
    parameter int FLAG_LEN  = 6,
    parameter int DELIM_LEN = 8,
    parameter int IFS_LEN   = 3
) (
    input  logic       SP,
    input  logic       reset,
    input  logic       RX,
    input  logic       bit_err,
    input  logic       stuff_err,
    input  logic       form_err,
    input  logic       ack_err,
    input  logic       crc_err,
    output logic       tx_dominant,
    output logic [2:0] err_code,
    output logic       chk_reset,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam int DOM_LIMIT = 14;
    localparam int MAX_A     = (FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN;
    localparam int MAX_B     = (MAX_A > DOM_LIMIT) ? MAX_A : DOM_LIMIT;
    localparam int CNT_MAX   = (MAX_B > IFS_LEN) ? MAX_B : IFS_LEN;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    // The recessive bit that ends DWAIT is delimiter bit 1, so DELIM itself
    // only sees DELIM_LEN-1 bits.
    localparam logic [CNT_W-1:0] FLAG_LAST  = CNT_W'(FLAG_LEN - 1);
    localparam logic [CNT_W-1:0] DOM_LAST   = CNT_W'(DOM_LIMIT - 1);
    localparam logic [CNT_W-1:0] DELIM_LAST = CNT_W'((DELIM_LEN >= 2) ? DELIM_LEN - 2 : 0);
    localparam logic [CNT_W-1:0] IFS_LAST   = CNT_W'(IFS_LEN - 1);

    localparam logic [2:0] CODE_NONE  = 3'd0;
    localparam logic [2:0] CODE_BIT   = 3'd1;
    localparam logic [2:0] CODE_STUFF = 3'd2;
    localparam logic [2:0] CODE_FORM  = 3'd3;
    localparam logic [2:0] CODE_ACK   = 3'd4;
    localparam logic [2:0] CODE_CRC   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLAG,
        S_DWAIT,
        S_DELIM,
        S_IFS
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       code_q, code_d;
    logic             chk_q, chk_d;
    logic             any_err;

    assign any_err = bit_err | stuff_err | form_err | ack_err | crc_err;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        chk_d   = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (any_err) begin
                    state_d = S_FLAG;
                    chk_d   = 1'b1;
                    if (bit_err)        code_d = CODE_BIT;
                    else if (stuff_err) code_d = CODE_STUFF;
                    else if (form_err)  code_d = CODE_FORM;
                    else if (ack_err)   code_d = CODE_ACK;
                    else                code_d = CODE_CRC;
                end
            end
            S_FLAG: begin
                if (cnt_q == FLAG_LAST) state_d = S_DWAIT;
            end
            S_DWAIT: begin
                if (RX) begin
                    state_d = (DELIM_LEN >= 2) ? S_DELIM : S_IFS;
                end else if (cnt_q == DOM_LAST) begin
                    state_d = S_FLAG;
                    code_d  = CODE_FORM;
                    chk_d   = 1'b1;
                end
            end
            S_DELIM: begin
                if (!RX) begin
                    state_d = S_FLAG;
                    code_d  = CODE_FORM;
                    chk_d   = 1'b1;
                end else if (cnt_q == DELIM_LAST) begin
                    state_d = S_IFS;
                end
            end
            S_IFS: begin
                // A dominant last bit is a new SOF and ends the frame just the same.
                if (cnt_q == IFS_LAST) begin
                    state_d = S_IDLE;
                    code_d  = CODE_NONE;
                end else if (!RX) begin
                    state_d = S_FLAG;
                    code_d  = CODE_FORM;
                    chk_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                code_d  = CODE_NONE;
            end
        endcase

        if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    end

    always_ff @(posedge SP) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= CODE_NONE;
            chk_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            chk_q   <= chk_d;
        end
    end

`ifdef ERR_FRAME_CNT_EN
    logic [7:0] err_cnt_q;

    // chk_d fires exactly once per error frame started, whatever its cause.
    always_ff @(posedge SP) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else if (chk_d && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign tx_dominant = (state_q == S_FLAG);
    assign busy        = (state_q != S_IDLE);
    assign err_code    = code_q;
    assign chk_reset   = chk_q;

endmodule

// File: tb/tb_error_frame_ctrl.sv
// tb/tb_error_frame_ctrl.sv - directed self-checking bench for error_frame_ctrl (ERR_FRAME_CNT_EN aware)
module tb_error_frame_ctrl;

    logic       SP;
    logic       reset;
    logic       RX;
    logic       bit_err, stuff_err, form_err, ack_err, crc_err;
    logic       tx_dominant;
    logic [2:0] err_code;
    logic       chk_reset;
    logic       busy;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    int n_tx, n_busy, n_chk;
    logic [2:0] exp_code;

    error_frame_ctrl #(.FLAG_LEN(6), .DELIM_LEN(8), .IFS_LEN(3)) dut (
        .SP          (SP),
        .reset       (reset),
        .RX          (RX),
        .bit_err     (bit_err),
        .stuff_err   (stuff_err),
        .form_err    (form_err),
        .ack_err     (ack_err),
        .crc_err     (crc_err),
        .tx_dominant (tx_dominant),
        .err_code    (err_code),
        .chk_reset   (chk_reset),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    initial SP = 1'b0;
    always #5 SP = ~SP;

    function automatic int exp_cnt(input int n);
`ifdef ERR_FRAME_CNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    task automatic step();
        @(posedge SP);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; RX = 1'b1;
        bit_err = 1'b0; stuff_err = 1'b0; form_err = 1'b0; ack_err = 1'b0; crc_err = 1'b0;

        // Reset state
        step();
        chk("rst_tx", tx_dominant, 0);
        chk("rst_code", err_code, 0);
        chk("rst_busy", busy, 0);
        chk("rst_chk", chk_reset, 1);
        chk("rst_cnt", err_cnt, 0);
        reset = 1'b0;
        step();
        chk("idle_chk", chk_reset, 0);
        chk("idle_busy", busy, 0);

        // Stuff error, clean frame: 6 flag bits, 17 busy bits
        stuff_err = 1'b1;
        step();
        stuff_err = 1'b0;
        chk("t1_code", err_code, 2);
        chk("t1_chk", chk_reset, 1);
        chk("t1_tx", tx_dominant, 1);
        chk("t1_cnt", err_cnt, exp_cnt(1));
        n_tx = 1; n_busy = 1; n_chk = 1;
        repeat (24) begin
            step();
            n_tx   += int'(tx_dominant);
            n_busy += int'(busy);
            n_chk  += int'(chk_reset);
        end
        chk("t1_ntx", n_tx, 6);
        chk("t1_nbusy", n_busy, 17);
        chk("t1_nchk", n_chk, 1);
        chk("t1_code_end", err_code, 0);
        chk("t1_busy_end", busy, 0);

        // bit + crc together: bit wins, one increment; strobes ignored in FLAG
        bit_err = 1'b1; crc_err = 1'b1;
        step();
        bit_err = 1'b0; crc_err = 1'b0;
        chk("t2_code", err_code, 1);
        chk("t2_cnt", err_cnt, exp_cnt(2));
        chk("t2_chk", chk_reset, 1);
        form_err = 1'b1; RX = 1'b0;
        repeat (5) step();
        chk("t2_flag_tx", tx_dominant, 1);
        chk("t2_flag_code", err_code, 1);
        chk("t2_flag_cnt", err_cnt, exp_cnt(2));
        chk("t2_flag_chk", chk_reset, 0);
        form_err = 1'b0; RX = 1'b1;
        step();
        chk("t2_dwait_tx", tx_dominant, 0);
        chk("t2_dwait_busy", busy, 1);

        // Dominant on delimiter bit 4 -> form error
        repeat (3) step();
        chk("t3_pre_tx", tx_dominant, 0);
        RX = 1'b0;
        step();
        chk("t3_tx", tx_dominant, 1);
        chk("t3_code", err_code, 3);
        chk("t3_chk", chk_reset, 1);
        chk("t3_cnt", err_cnt, exp_cnt(3));

        // 14 dominant bits in DWAIT -> flag restart
        repeat (6) step();
        chk("t4_dwait_tx", tx_dominant, 0);
        chk("t4_dwait_busy", busy, 1);
        repeat (13) step();
        chk("t4_13_tx", tx_dominant, 0);
        chk("t4_13_chk", chk_reset, 0);
        chk("t4_13_cnt", err_cnt, exp_cnt(3));
        step();
        chk("t4_14_tx", tx_dominant, 1);
        chk("t4_14_code", err_code, 3);
        chk("t4_14_chk", chk_reset, 1);
        chk("t4_14_cnt", err_cnt, exp_cnt(4));

        // Dominant on first IFS bit -> form error
        RX = 1'b1;
        repeat (14) step();
        chk("t5_ifs_tx", tx_dominant, 0);
        RX = 1'b0;
        step();
        chk("t5_tx", tx_dominant, 1);
        chk("t5_code", err_code, 3);
        chk("t5_cnt", err_cnt, exp_cnt(5));

        // Dominant on last IFS bit -> straight to IDLE
        RX = 1'b1;
        repeat (16) step();
        chk("t5b_busy_pre", busy, 1);
        RX = 1'b0;
        step();
        chk("t5b_busy", busy, 0);
        chk("t5b_code", err_code, 0);
        chk("t5b_chk", chk_reset, 0);
        chk("t5b_cnt", err_cnt, exp_cnt(5));
        RX = 1'b1;

        // Reset during the 3rd flag bit, colliding with an error strobe
        ack_err = 1'b1;
        step();
        ack_err = 1'b0;
        chk("t6_code", err_code, 4);
        chk("t6_cnt", err_cnt, exp_cnt(6));
        repeat (2) step();
        chk("t6_flag_tx", tx_dominant, 1);
        reset = 1'b1; bit_err = 1'b1;
        step();
        chk("t6_rst_tx", tx_dominant, 0);
        chk("t6_rst_code", err_code, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_chk", chk_reset, 1);
        chk("t6_rst_cnt", err_cnt, 0);
        reset = 1'b0; bit_err = 1'b0;
        step();
        chk("t6_post_busy", busy, 0);
        chk("t6_post_chk", chk_reset, 0);

        // 300 frames: saturation at 255 (or 0 throughout without the counter)
        for (int i = 0; i < 300; i++) begin
            case (i % 4)
                0: begin form_err = 1'b1; ack_err = 1'b1; crc_err = 1'b1; exp_code = 3'd3; end
                1: begin crc_err = 1'b1; exp_code = 3'd5; end
                2: begin stuff_err = 1'b1; form_err = 1'b1; exp_code = 3'd2; end
                default: begin ack_err = 1'b1; crc_err = 1'b1; exp_code = 3'd4; end
            endcase
            step();
            bit_err = 1'b0; stuff_err = 1'b0; form_err = 1'b0; ack_err = 1'b0; crc_err = 1'b0;
            chk("t7_code", err_code, exp_code);
            chk("t7_cnt", err_cnt, exp_cnt(i + 1));
            repeat (17) step();
        end
        chk("t7_busy_end", busy, 0);
        chk("t7_cnt_end", err_cnt, exp_cnt(300));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/error_frame_ctrl.md
ERROR_FRAME_CTRL -- requirements
Module: error_frame_ctrl

Interface
REQ-001 SHALL have parameter FLAG_LEN, default 6, the number of error-flag bits driven dominant.
REQ-002 SHALL have parameter DELIM_LEN, default 8, the number of recessive error-delimiter bits.
REQ-003 SHALL have parameter IFS_LEN, default 3, the number of intermission bits before returning to idle.
REQ-004 SHALL have port SP, input, 1 bit: the sole clock, one rising edge per bit sample point; reset is synchronous and active-high.
REQ-005 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port RX, input, 1 bit: the sampled bus level, where 0 is dominant.
REQ-007 SHALL have ports bit_err, stuff_err, form_err, ack_err and crc_err, each an input, 1 bit: active-high error strobes from the field checkers.
REQ-008 SHALL have port tx_dominant, output, 1 bit: request to drive the bus dominant.
REQ-009 SHALL have port err_code, output, 3 bits: the latched error cause (0 none, 1 bit, 2 stuff, 3 form, 4 ack, 5 crc).
REQ-010 SHALL have port chk_reset, output, 1 bit: a one-cycle pulse that clears all field checkers.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port err_cnt, output, 8 bits: the count of error frames started.

Function
REQ-013 SHALL implement the states IDLE, FLAG, DWAIT, DELIM and IFS.
REQ-014 SHALL, in IDLE with any error strobe high at an SP edge, on that edge: latch err_code by priority bit>stuff>form>ack>crc, pulse chk_reset, enter FLAG and clear the bit counter.
REQ-015 SHALL hold tx_dominant=1 exactly for the FLAG_LEN SP cycles spent in FLAG, then enter DWAIT with tx_dominant=0.
REQ-016 SHALL, in FLAG, ignore all error strobes and RX.
REQ-017 SHALL, in DWAIT, stay while RX=0 and enter DELIM on the first edge with RX=1, counting that bit as delimiter bit 1.
REQ-018 SHALL, in DWAIT, count consecutive dominant bits and, on the 14th, restart FLAG with err_code=3 (form), pulse chk_reset and increment err_cnt.
REQ-019 SHALL, in DELIM, advance while RX=1 and enter IFS after DELIM_LEN recessive bits in total.
REQ-020 SHALL, in DELIM, treat RX=0 as a form error: enter FLAG, set err_code=3, pulse chk_reset and increment err_cnt.
REQ-021 SHALL, in IFS, count IFS_LEN bits, then enter IDLE and clear err_code to 0.
REQ-022 SHALL, in IFS, treat RX=0 on the last bit as start of frame and go to IDLE directly.
REQ-023 SHALL, in IFS, treat RX=0 before the last bit as a form error handled as in REQ-020.
REQ-024 SHALL, when several strobes are high on the same edge, record only the highest-priority cause and increment err_cnt by exactly 1.
REQ-025 SHALL saturate err_cnt at 255 with no wrap-around.
REQ-026 SHALL size every bit counter to hold max(FLAG_LEN, DELIM_LEN, 14), and SHALL clear it on every state change.

Reset
REQ-027 SHALL, on reset=1 at an SP edge, enter IDLE from any state, including mid-FLAG, and set tx_dominant=0, err_code=0, busy=0, chk_reset=1 for that cycle and err_cnt=0.
REQ-028 SHALL give reset priority over all error strobes on the same edge.

Configuration
REQ-029 SHALL compile the err_cnt counter and its increment logic only when ERR_FRAME_CNT_EN is defined.
REQ-030 SHALL, when ERR_FRAME_CNT_EN is undefined, tie err_cnt to 8'd0 with no counter flops, leaving all other behaviour unchanged.

Verification
REQ-031 SHALL cover: stuff_err pulse in IDLE with RX=1 afterwards -> err_code=2, tx_dominant=1 for 6 edges, busy for 6+8+3=17 edges, then IDLE and err_cnt=1.
REQ-032 SHALL cover: bit_err and crc_err high together -> err_code=1, err_cnt increments by 1.
REQ-033 SHALL cover: RX=0 on delimiter bit 4 -> new FLAG, err_code=3, err_cnt=2, chk_reset pulse.
REQ-034 SHALL cover: RX held 0 for 14 bits in DWAIT -> FLAG restart, err_code=3.
REQ-035 SHALL cover: reset on the 3rd FLAG bit -> next cycle tx_dominant=0, err_code=0, err_cnt=0, IDLE.
REQ-036 SHALL cover: 300 error frames with the macro defined -> err_cnt=255; the same run without the macro -> err_cnt=0 throughout.
